// File: rtl/mult_datapath.sv
// Datapath for the repeated-addition multiplier (P = A x B).
// Responder to the multiplier control FSM: executes its strobes, returns eqz.
//
// Ports:
//   clk      rising-edge system clock
//   rst      asynchronous active-low reset
//   data_in  shared operand bus, sampled by ld_a / ld_b
//   ld_a     load A from data_in
//   ld_b     load B (iteration counter) from data_in; wins over dec
//   ld_p     accumulate P <= P + A (old A if ld_a in the same cycle)
//   dec      saturating decrement of B
//   clr      clear P and ovf; wins over ld_p
//   eqz      B == 0, combinational from the B register
//   product  P register
//   a_val    A register
//   b_val    B register
//   ovf      sticky carry-out of the P accumulator
module mult_datapath #(
    parameter int WIDTH  = 16,
    parameter int PWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              ld_a,
    input  logic              ld_b,
    input  logic              ld_p,
    input  logic              dec,
    input  logic              clr,
    output logic              eqz,
    output logic [PWIDTH-1:0] product,
    output logic [WIDTH-1:0]  a_val,
    output logic [WIDTH-1:0]  b_val,
    output logic              ovf
);

    // One extra bit so the carry out of P is visible for the ovf flag.
    logic [PWIDTH:0] sum;

    assign sum = {1'b0, product}
               + {{(PWIDTH + 1 - WIDTH){1'b0}}, a_val};

    assign eqz = (b_val == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_val <= '0;
        end else if (ld_a) begin
            a_val <= data_in;
        end
    end

    // Counter saturates at zero so a stray dec never wraps to all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_val <= '0;
        end else if (ld_b) begin
            b_val <= data_in;
        end else if (dec && !eqz) begin
            b_val <= b_val - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            product <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            product <= '0;
            ovf     <= 1'b0;
        end else if (ld_p) begin
            product <= sum[PWIDTH-1:0];
            ovf     <= ovf | sum[PWIDTH];
        end
    end

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: scoreboard of a behavioural model
// plus directed checks, on a 16/32 instance and an 8/8 overflow instance.
module tb_mult_datapath;

    typedef struct packed {
        logic [31:0] p;
        logic [15:0] a;
        logic [15:0] b;
        logic        ovf;
        logic        eqz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        ld_a, ld_b, ld_p, dec, clr;
    logic        eqz, ovf;
    logic [31:0] product;
    logic [15:0] a_val, b_val;

    logic [7:0]  d8;
    logic        la8, lb8, lp8, dc8, cl8;
    logic        eqz8, ovf8;
    logic [7:0]  p8, a8, b8;

    int n_tests;
    int n_fail;

    exp_t sb[$];

    logic [15:0] m_a, m_b;
    logic [31:0] m_p;
    logic        m_ovf;

    mult_datapath #(.WIDTH(16), .PWIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .ld_p    (ld_p),
        .dec     (dec),
        .clr     (clr),
        .eqz     (eqz),
        .product (product),
        .a_val   (a_val),
        .b_val   (b_val),
        .ovf     (ovf)
    );

    mult_datapath #(.WIDTH(8), .PWIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .data_in (d8),
        .ld_a    (la8),
        .ld_b    (lb8),
        .ld_p    (lp8),
        .dec     (dc8),
        .clr     (cl8),
        .eqz     (eqz8),
        .product (p8),
        .a_val   (a8),
        .b_val   (b8),
        .ovf     (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a   = '0;
        m_b   = '0;
        m_p   = '0;
        m_ovf = 1'b0;
    endtask

    // Drive one strobe cycle, push the model's prediction, then pop and
    // compare against the DUT just after the edge.
    task automatic step(input logic la, input logic lb, input logic lp,
                        input logic dc, input logic cl,
                        input logic [15:0] din);
        logic [32:0] s;
        exp_t e;
        data_in = din;
        ld_a = la; ld_b = lb; ld_p = lp; dec = dc; clr = cl;
        s = {1'b0, m_p} + {17'd0, m_a};
        if (cl) begin
            m_p = '0; m_ovf = 1'b0;
        end else if (lp) begin
            m_p = s[31:0]; m_ovf = m_ovf | s[32];
        end
        if (lb) m_b = din;
        else if (dc && m_b != 0) m_b = m_b - 16'd1;
        if (la) m_a = din;
        e.p = m_p; e.a = m_a; e.b = m_b; e.ovf = m_ovf;
        e.eqz = (m_b == 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        ld_a = 0; ld_b = 0; ld_p = 0; dec = 0; clr = 0;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_p",   {32'd0, product}, {32'd0, e.p});
            chk("sb_a",   {48'd0, a_val},   {48'd0, e.a});
            chk("sb_b",   {48'd0, b_val},   {48'd0, e.b});
            chk("sb_ovf", {63'd0, ovf},     {63'd0, e.ovf});
            chk("sb_eqz", {63'd0, eqz},     {63'd0, e.eqz});
        end
    endtask

    task automatic step8(input logic la, input logic lp, input logic cl,
                         input logic [7:0] din);
        d8 = din; la8 = la; lp8 = lp; cl8 = cl;
        @(posedge clk);
        #1;
        la8 = 0; lp8 = 0; cl8 = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        data_in = '0;
        ld_a = 0; ld_b = 0; ld_p = 0; dec = 0; clr = 0;
        d8 = '0; la8 = 0; lb8 = 0; lp8 = 0; dc8 = 0; cl8 = 0;
        model_reset();
        #2;
        chk("rst_p",   {32'd0, product}, 64'd0);
        chk("rst_a",   {48'd0, a_val},   64'd0);
        chk("rst_b",   {48'd0, b_val},   64'd0);
        chk("rst_ovf", {63'd0, ovf},     64'd0);
        chk("rst_eqz", {63'd0, eqz},     64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 5 x 3
        step(1, 0, 0, 0, 0, 16'd5);
        step(0, 1, 0, 0, 1, 16'd3);
        step(0, 0, 1, 1, 0, 16'hAAAA);
        step(0, 0, 1, 1, 0, 16'hAAAA);
        chk("mul_eqz_pre", {63'd0, eqz}, 64'd0);
        step(0, 0, 1, 1, 0, 16'hAAAA);
        chk("mul_p",   {32'd0, product}, 64'd15);
        chk("mul_b",   {48'd0, b_val},   64'd0);
        chk("mul_eqz", {63'd0, eqz},     64'd1);
        chk("mul_ovf", {63'd0, ovf},     64'd0);

        // Zero operand, saturating dec
        step(1, 0, 0, 0, 0, 16'd7);
        step(0, 1, 0, 0, 0, 16'd0);
        chk("zero_eqz", {63'd0, eqz}, 64'd1);
        step(0, 0, 0, 1, 0, 16'h1234);
        chk("zero_sat", {48'd0, b_val}, 64'd0);

        // Priority: clr over ld_p, ld_b over dec
        chk("pri_p_pre", {32'd0, product}, 64'd15);
        step(0, 0, 1, 0, 1, 16'd0);
        chk("pri_clr", {32'd0, product}, 64'd0);
        step(0, 1, 0, 1, 0, 16'd9);
        chk("pri_ldb", {48'd0, b_val}, 64'd9);

        // Same-edge hazard: ld_p uses old A
        step(1, 0, 0, 0, 1, 16'd4);
        step(1, 0, 1, 0, 0, 16'd10);
        chk("haz_p", {32'd0, product}, 64'd4);
        chk("haz_a", {48'd0, a_val},   64'd10);
        step(0, 0, 1, 0, 0, 16'd0);
        chk("haz_p2", {32'd0, product}, 64'd14);

        // 8-bit overflow instance
        step8(1, 0, 1, 8'd200);
        step8(0, 1, 0, 8'd0);
        chk("ovf_p1",   {56'd0, p8},   64'd200);
        chk("ovf_f1",   {63'd0, ovf8}, 64'd0);
        step8(0, 1, 0, 8'd0);
        chk("ovf_p2",   {56'd0, p8},   64'd144);
        chk("ovf_f2",   {63'd0, ovf8}, 64'd1);
        step8(0, 1, 0, 8'd0);
        chk("ovf_p3",   {56'd0, p8},   64'd88);
        chk("ovf_stky", {63'd0, ovf8}, 64'd1);
        step8(0, 0, 1, 8'd0);
        chk("ovf_clrp", {56'd0, p8},   64'd0);
        chk("ovf_clrf", {63'd0, ovf8}, 64'd0);

        // Random strobes against the model
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)),     1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0), 16'($urandom));
        end

        // Reset mid-loop: 6 x 5
        step(1, 0, 0, 0, 0, 16'd6);
        step(0, 1, 0, 0, 1, 16'd5);
        step(0, 0, 1, 1, 0, 16'd0);
        step(0, 0, 1, 1, 0, 16'd0);
        chk("mid_p_pre", {32'd0, product}, 64'd12);
        ld_p = 1; dec = 1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_p",   {32'd0, product}, 64'd0);
        chk("mid_a",   {48'd0, a_val},   64'd0);
        chk("mid_b",   {48'd0, b_val},   64'd0);
        chk("mid_ovf", {63'd0, ovf},     64'd0);
        chk("mid_eqz", {63'd0, eqz},     64'd1);
        ld_p = 0; dec = 0;
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 16'hFFFF);
        step(0, 0, 0, 0, 0, 16'h5555);
        chk("post_p", {32'd0, product}, 64'd0);
        chk("post_eqz", {63'd0, eqz},   64'd1);

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Datapath for the repeated-addition multiplier, P = A × B.
- Sits under the multiplier control FSM and is the responder end of that control interface.
- Executes the FSM's strobes: ld_a, ld_b, ld_p, dec, clr.
- Returns the status flag eqz (B counter reached zero), which the FSM uses to terminate the accumulation loop.

Parameters:
- WIDTH, 16, width of the data_in bus and of operand registers A and B.
- PWIDTH, 32, width of the product accumulator P. Must be >= WIDTH. May be set below 2*WIDTH; overflow is then flagged.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset is asynchronous and active-low.
- data_in  input  WIDTH  shared operand bus, sampled by ld_a / ld_b.
- ld_a  input  1  load A from data_in.
- ld_b  input  1  load B (iteration counter) from data_in.
- ld_p  input  1  accumulate: P <= P + A.
- dec  input  1  decrement B by one.
- clr  input  1  clear P and the overflow flag.
- eqz  output  1  high when B == 0.
- product  output  PWIDTH  current value of P.
- a_val  output  WIDTH  current value of A (debug/observe).
- b_val  output  WIDTH  current value of B (debug/observe).
- ovf  output  1  sticky flag: some accumulation carried out of PWIDTH.

Behaviour:
- Reset (rst low, asynchronous): A, B, P, ovf = 0; eqz therefore = 1. Reset takes effect immediately, including mid-operation. After release, registers hold until the next strobe.
- All register updates occur on the rising edge of clk when rst is high. With no strobe asserted, all registers hold.
- A register:
  - ld_a=1 -> A <= data_in.
  - Otherwise hold.
- B register, priority ld_b > dec:
  - ld_b=1 -> B <= data_in, even if dec=1.
  - dec=1 and B != 0 -> B <= B - 1.
  - dec=1 and B == 0 -> B holds at 0 (saturating, no wrap to all-ones).
- P register, priority clr > ld_p:
  - clr=1 -> P <= 0 and ovf <= 0, even if ld_p=1.
  - ld_p=1 -> P <= (P + zero-extended A) mod 2^PWIDTH. If the PWIDTH+1-bit sum has its carry bit set, ovf <= 1 (sticky until clr or reset).
- Simultaneous strobes:
  - ld_a and ld_b together both load the same data_in value.
  - ld_p in the same cycle as ld_a adds the OLD A value (pre-edge).
  - ld_p with dec: both take effect in one cycle. This is the normal loop step.
- eqz:
  - Combinational decode of the B register: eqz = (B == 0). No added latency.
  - Goes high in the cycle after the edge where B transitions 1 -> 0.
  - Unaffected by data_in until ld_b is applied.
- product, a_val, b_val: direct register outputs, no combinational path from inputs.
- Loop latency: for B loaded with N and A with M, N cycles of (ld_p & dec) after clr give P = M×N and eqz = 1. A strobe cycle with B already 0 still adds A; stopping the loop is the controller's responsibility.
- No X propagation: all registers are defined from reset. Strobes are assumed synchronous to clk.

Test Plan:
- Reset, then 5 × 3: data_in=5 with ld_a; data_in=3 with ld_b and clr in one cycle; then 3 cycles of ld_p+dec. Required: product=15, b_val=0, eqz rises after the 3rd edge, ovf=0.
- Zero operand: ld_a with 7, ld_b with 0. Required: eqz=1 immediately after the load edge. One dec cycle leaves b_val=0 (saturates, no wrap to 0xFFFF).
- Overflow, WIDTH=8, PWIDTH=8: A=200, clr, then two ld_p cycles. Required: product=144 and ovf=1 after the second edge. A following clr gives product=0, ovf=0.
- Priority: P=15, then clr+ld_p in one cycle -> product=0. ld_b(data_in=9)+dec in one cycle -> b_val=9.
- Same-edge hazard: A=4, P=0; ld_a(data_in=10)+ld_p together -> product=4, a_val=10. Next ld_p -> product=14.
- Reset mid-loop: during a 6 × 5 accumulation, pull rst low between edges. Required: product, a_val, b_val, ovf = 0 and eqz=1 without waiting for clk; values stay there after release.
